// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO: pops one byte at a time and sends
// start bit, DATA_W data bits (LSB first), optional even parity and one stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b0,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_re,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle, StPop, StLoad, StStart, StData, StParity, StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              bit_end;

    assign bit_end = (cnt_q == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (tx_en && !fifo_empty) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StLoad;
            end
            // FIFO output is valid here, one cycle after the read strobe.
            StLoad: begin
                shift_d  = fifo_data;
                parity_d = ^fifo_data;
                cnt_d    = '0;
                state_d  = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only, so reset forces them immediately.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            StStart:  tx = 1'b0;
            StData:   tx = shift_q[0];
            StParity: tx = parity_q;
            default:  tx = 1'b1;
        endcase
        fifo_re = (state_q == StPop);
        busy    = (state_q != StIdle);
        tx_done = (state_q == StStop) && bit_end;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) fed by FIFO models,
// with a byte scoreboard checked bit-by-bit against the serial line.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [1:0] fifo_empty, fifo_re, tx, busy, tx_done;
    logic [7:0] fdata0 = 8'h00;
    logic [7:0] fdata1 = 8'h00;

    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    int         wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    int         uf_cnt = 0;
    int         cyc = 0;
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int         n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty[0] = (rd0 == wr0);
    assign fifo_empty[1] = (rd1 == wr1);

    always @(posedge clk) begin
        if (fifo_re[0]) begin
            if (rd0 == wr0) uf_cnt <= uf_cnt + 1;
            else begin
                fdata0 <= mem0[rd0[5:0]];
                rd0    <= rd0 + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (fifo_re[1]) begin
            if (rd1 == wr1) uf_cnt <= uf_cnt + 1;
            else begin
                fdata1 <= mem1[rd1[5:0]];
                rd1    <= rd1 + 1;
            end
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .DATA_W(8)) dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty[0]), .fifo_data(fdata0),
        .fifo_re(fifo_re[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty[1]), .fifo_data(fdata1),
        .fifo_re(fifo_re[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_byte(input int which, input logic [7:0] b);
        if (which == 0) begin
            mem0[wr0[5:0]] = b;
            wr0++;
            exp0.push_back(b);
        end else begin
            mem1[wr1[5:0]] = b;
            wr1++;
            exp1.push_back(b);
        end
    endtask

    task automatic wait_pop(input int which, output int pc, output bit ok);
        ok = 1'b0;
        pc = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (fifo_re[which] === 1'b1) begin
                ok = 1'b1;
                pc = cyc;
            end
        end
        if (!ok) chk("pop_timeout", 32'd0, 32'd1);
    endtask

    // Checks one whole frame from the POP cycle to the following IDLE cycle.
    // drop_bit >= 0 lowers tx_en at the start of that data bit.
    task automatic check_frame(input int which, input int drop_bit, output int pc);
        bit          ok;
        logic [7:0]  b;
        logic [10:0] bits_v;
        int          nbits;
        wait_pop(which, pc, ok);
        if (!ok) return;
        if (which == 0) begin
            if (exp0.size() == 0) begin chk("sb_empty0", 32'd0, 32'd1); return; end
            b = exp0.pop_front();
        end else begin
            if (exp1.size() == 0) begin chk("sb_empty1", 32'd0, 32'd1); return; end
            b = exp1.pop_front();
        end
        nbits  = (which == 0) ? 10 : 11;
        bits_v = '1;
        bits_v[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits_v[i+1] = b[i];
        if (which == 1) bits_v[9] = ^b;
        chk("pop_busy", {31'd0, busy[which]}, 32'd1);
        chk("pop_tx", {31'd0, tx[which]}, 32'd1);
        @(negedge clk);
        chk("load_re", {31'd0, fifo_re[which]}, 32'd0);
        chk("load_tx", {31'd0, tx[which]}, 32'd1);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (drop_bit >= 0 && k == drop_bit + 1 && c == 0) tx_en = 1'b0;
                chk($sformatf("bit%0d_of_%02h", k, b), {31'd0, tx[which]}, {31'd0, bits_v[k]});
                chk("tx_done", {31'd0, tx_done[which]},
                    {31'd0, (k == nbits - 1) && (c == CPB - 1)});
                chk("frame_busy", {31'd0, busy[which]}, 32'd1);
                chk("frame_re", {31'd0, fifo_re[which]}, 32'd0);
            end
        end
        @(negedge clk);
        chk("idle_busy", {31'd0, busy[which]}, 32'd0);
        chk("idle_tx", {31'd0, tx[which]}, 32'd1);
    endtask

    initial begin
        int  pc, prev, rc;
        bit  ok;
        logic [7:0] dropped;
        rst   = 1'b1;
        tx_en = 1'b0;
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("rst_tx", {31'd0, tx[w]}, 32'd1);
            chk("rst_re", {31'd0, fifo_re[w]}, 32'd0);
            chk("rst_busy", {31'd0, busy[w]}, 32'd0);
            chk("rst_done", {31'd0, tx_done[w]}, 32'd0);
        end
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        tx_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_empty_re", {31'd0, fifo_re[0]}, 32'd0);
            chk("idle_empty_tx", {31'd0, tx[0]}, 32'd1);
        end

        // Single byte, no parity
        push_byte(0, 8'hA5);
        check_frame(0, -1, pc);

        // Even parity: 0x07 -> 1, 0x03 -> 0
        push_byte(1, 8'h07);
        push_byte(1, 8'h03);
        check_frame(1, -1, prev);
        check_frame(1, -1, pc);
        chk("parity_spacing", pc - prev, 3 + 11 * CPB);

        // Drain 16 bytes back-to-back
        for (int i = 0; i < 16; i++) push_byte(0, 8'(i));
        for (int i = 0; i < 16; i++) begin
            check_frame(0, -1, pc);
            if (i > 0) chk("drain_spacing", pc - prev, 3 + 10 * CPB);
            prev = pc;
        end
        chk("drain_empty", {31'd0, fifo_empty[0]}, 32'd1);
        repeat (30) begin
            @(negedge clk);
            chk("post_drain_re", {31'd0, fifo_re[0]}, 32'd0);
            chk("post_drain_tx", {31'd0, tx[0]}, 32'd1);
        end

        // tx_en dropped during byte 1 data phase
        push_byte(0, 8'h11);
        push_byte(0, 8'h22);
        push_byte(0, 8'h33);
        check_frame(0, 3, pc);
        repeat (20) begin
            @(negedge clk);
            chk("gated_re", {31'd0, fifo_re[0]}, 32'd0);
            chk("gated_busy", {31'd0, busy[0]}, 32'd0);
        end
        tx_en = 1'b1;
        check_frame(0, -1, pc);
        check_frame(0, -1, pc);

        // Reset in the middle of data bit 3; the popped byte is lost
        push_byte(0, 8'h55);
        wait_pop(0, pc, ok);
        if (ok) begin
            dropped = exp0.pop_front();
            repeat (1 + CPB + 3 * CPB + 1) @(negedge clk);
            chk("pre_rst_bit3", {31'd0, tx[0]}, {31'd0, dropped[3]});
            #2 rst = 1'b1;
            #1;
            chk("async_rst_tx", {31'd0, tx[0]}, 32'd1);
            chk("async_rst_re", {31'd0, fifo_re[0]}, 32'd0);
            chk("async_rst_busy", {31'd0, busy[0]}, 32'd0);
            chk("async_rst_done", {31'd0, tx_done[0]}, 32'd0);
            push_byte(0, 8'h3C);
            @(negedge clk);
            @(negedge clk);
            chk("in_rst_busy", {31'd0, busy[0]}, 32'd0);
            rst = 1'b0;
            rc  = cyc;
            check_frame(0, -1, pc);
            chk("pop_after_rst", pc - rc, 32'd1);
        end

        chk("underflow", uf_cnt, 32'd0);
        chk("sb_left0", exp0.size(), 32'd0);
        chk("sb_left1", exp1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
